// File: rtl/data_mem_responder.sv
// Word-addressed data memory behind a valid/ready request/response pair.
// Ports: clk, rst (sync active-low), req_* in, req_ready out, rsp_* out, rsp_ready in.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW =
    (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  localparam logic [32:0] LIMIT =
    33'(DEPTH_WORDS) << 2;

  localparam logic [3:0] LAT = 4'(LATENCY);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic        l_we;
  logic [31:0] l_addr;
  logic [31:0] l_wdata;
  logic [3:0]  l_be;

  logic [31:0] mem [DEPTH_WORDS];

  logic          acc_err;
  logic          access;
  logic          commit;
  logic [AW-1:0] idx;

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);

  // Misaligned or past the end of storage.
  assign acc_err = (|l_addr[1:0]) ||
                   ({1'b0, l_addr} >= LIMIT);

  assign idx    = l_addr[AW+1:2];
  assign access = (state == WAIT) && (cnt == 4'd0);

  // Reset on the access edge discards the write.
  assign commit = rst && access &&
                  l_we && !acc_err;

  // Storage has no reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int i = 0; i < 4; i++) begin
        if (l_be[i])
          mem[idx][8*i +: 8] <= l_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      l_we      <= 1'b0;
      l_addr    <= 32'd0;
      l_wdata   <= 32'd0;
      l_be      <= 4'd0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            l_we    <= req_we;
            l_addr  <= req_addr;
            l_wdata <= req_wdata;
            l_be    <= req_be;
            cnt     <= LAT;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state   <= RESP;
            rsp_err <= acc_err;
            if (acc_err || l_we)
              rsp_rdata <= 32'd0;
            else
              rsp_rdata <= mem[idx];
          end
        end
        RESP: begin
          if (rsp_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder.
// Instance a uses LATENCY=2, instance b uses LATENCY=0.
module tb_data_mem_responder;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  logic        a_req_valid, a_req_ready, a_req_we;
  logic [31:0] a_req_addr, a_req_wdata;
  logic [3:0]  a_req_be;
  logic        a_rsp_valid, a_rsp_ready, a_rsp_err;
  logic [31:0] a_rsp_rdata;

  logic        b_req_valid, b_req_ready, b_req_we;
  logic [31:0] b_req_addr, b_req_wdata;
  logic [3:0]  b_req_be;
  logic        b_rsp_valid, b_rsp_ready, b_rsp_err;
  logic [31:0] b_rsp_rdata;

  data_mem_responder #(
    .DEPTH_WORDS(1024),
    .LATENCY(2)
  ) u_a (
    .clk(clk), .rst(rst),
    .req_valid(a_req_valid), .req_ready(a_req_ready),
    .req_we(a_req_we), .req_addr(a_req_addr),
    .req_wdata(a_req_wdata), .req_be(a_req_be),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
    .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err)
  );

  data_mem_responder #(
    .DEPTH_WORDS(1024),
    .LATENCY(0)
  ) u_b (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_we(b_req_we), .req_addr(b_req_addr),
    .req_wdata(b_req_wdata), .req_be(b_req_be),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
    .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h",
               tag, obs, exp);
    end
  endtask

  // One full transaction on instance a; request
  // fields are scrambled right after acceptance.
  task automatic a_xact(input logic we,
                        input logic [31:0] addr,
                        input logic [31:0] wd,
                        input logic [3:0] be,
                        output logic [31:0] rd,
                        output logic er,
                        output int lat);
    a_req_valid = 1'b1;
    a_req_we    = we;
    a_req_addr  = addr;
    a_req_wdata = wd;
    a_req_be    = be;
    @(posedge clk); #1;
    a_req_valid = 1'b0;
    a_req_we    = ~we;
    a_req_addr  = ~addr;
    a_req_wdata = ~wd;
    a_req_be    = ~be;
    lat = 0;
    while (!a_rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = a_rsp_rdata;
    er = a_rsp_err;
    a_rsp_ready = 1'b1;
    @(posedge clk); #1;
    a_rsp_ready = 1'b0;
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;
  int          seen;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    a_req_valid = 0; a_req_we = 0;
    a_req_addr = 0; a_req_wdata = 0;
    a_req_be = 0; a_rsp_ready = 0;
    b_req_valid = 0; b_req_we = 0;
    b_req_addr = 0; b_req_wdata = 0;
    b_req_be = 0; b_rsp_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(a_req_ready), 1);
    check("rst_rsp_valid", 32'(a_rsp_valid), 0);
    check("rst_rdata", a_rsp_rdata, 0);
    check("rst_err", 32'(a_rsp_err), 0);
    rst = 1'b1;

    // LATENCY=0 back-to-back, rsp_ready tied high
    b_rsp_ready = 1'b1;
    b_req_valid = 1'b1;
    b_req_we    = 1'b1;
    b_req_addr  = 32'h8;
    b_req_wdata = 32'hCAFE0000;
    b_req_be    = 4'hF;
    for (int i = 0; i < 9; i++) begin
      check($sformatf("b_ready%0d", i),
            32'(b_req_ready), 32'(i % 3 == 0));
      check($sformatf("b_valid%0d", i),
            32'(b_rsp_valid), 32'(i % 3 == 2));
      if (i % 3 == 2)
        check("b_err", 32'(b_rsp_err), 0);
      @(posedge clk); #1;
    end
    b_req_valid = 1'b0;

    // full write then read
    a_xact(1, 32'h10, 32'hDEADBEEF, 4'hF,
           rd, er, lat);
    check("wr_lat", lat, 3);
    check("wr_err", 32'(er), 0);
    check("wr_rdata", rd, 0);
    a_xact(0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    check("rd_lat", lat, 3);
    check("rd_data", rd, 32'hDEADBEEF);
    check("rd_err", 32'(er), 0);

    // partial byte write
    a_xact(1, 32'h10, 32'h11223344, 4'b0101,
           rd, er, lat);
    a_xact(0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    check("be_data", rd, 32'hDE22BE44);

    // error cases
    a_xact(0, 32'h12, 32'h0, 4'h0, rd, er, lat);
    check("mis_err", 32'(er), 1);
    check("mis_rdata", rd, 0);
    a_xact(0, 32'h1000, 32'h0, 4'h0, rd, er, lat);
    check("oor_err", 32'(er), 1);
    check("oor_rdata", rd, 0);
    a_xact(1, 32'h12, 32'hFFFFFFFF, 4'hF,
           rd, er, lat);
    check("mis_wr_err", 32'(er), 1);
    a_xact(1, 32'h1010, 32'hFFFFFFFF, 4'hF,
           rd, er, lat);
    check("oor_wr_err", 32'(er), 1);
    a_xact(1, 32'h10, 32'hFFFFFFFF, 4'h0,
           rd, er, lat);
    check("be0_err", 32'(er), 0);
    a_xact(0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    check("reread", rd, 32'hDE22BE44);

    // back-pressure in RESP
    a_req_valid = 1'b1;
    a_req_we    = 1'b0;
    a_req_addr  = 32'h10;
    @(posedge clk); #1;
    a_req_valid = 1'b0;
    lat = 0;
    while (!a_rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("bp_lat", lat, 3);
    for (int i = 0; i < 5; i++) begin
      a_req_valid = i[0];
      a_req_we    = 1'b1;
      a_req_addr  = 32'(i * 4);
      @(posedge clk); #1;
      check("bp_valid", 32'(a_rsp_valid), 1);
      check("bp_rdata", a_rsp_rdata,
            32'hDE22BE44);
      check("bp_ready", 32'(a_req_ready), 0);
    end
    a_req_valid = 1'b1;
    a_req_we    = 1'b0;
    a_rsp_ready = 1'b1;
    @(posedge clk); #1;
    a_rsp_ready = 1'b0;
    check("bp_rel_valid", 32'(a_rsp_valid), 0);
    check("bp_rel_ready", 32'(a_req_ready), 1);
    a_req_valid = 1'b0;
    @(posedge clk); #1;

    // reset in WAIT discards the write
    a_xact(1, 32'h20, 32'h12345678, 4'hF,
           rd, er, lat);
    a_req_valid = 1'b1;
    a_req_we    = 1'b1;
    a_req_addr  = 32'h20;
    a_req_wdata = 32'h55AA55AA;
    a_req_be    = 4'hF;
    @(posedge clk); #1;
    a_req_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    check("wrst_ready", 32'(a_req_ready), 1);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (a_rsp_valid) seen++;
      @(posedge clk); #1;
    end
    check("wrst_no_rsp", seen, 0);
    a_xact(0, 32'h20, 32'h0, 4'h0, rd, er, lat);
    check("wrst_data", rd, 32'h12345678);
    a_xact(0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    check("rst_keeps_mem", rd, 32'hDE22BE44);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 1024, giving the number of 32-bit words of storage.
REQ-002 The block SHALL have parameter LATENCY, default 2, giving the number of wait cycles between request acceptance and the access (0..15).
REQ-003 clk  input  1  single clock; all state SHALL change on its rising edge only.
REQ-004 rst  input  1  synchronous active-low reset; sampled on rising clk; rst=0 resets.
REQ-005 req_valid  input  1  initiator presents a request.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 req_we  input  1  1 = write, 0 = read.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  write data.
REQ-010 req_be  input  4  byte-lane write enables; bit i covers bits 8i+7:8i.
REQ-011 rsp_valid  output  1  response available.
REQ-012 rsp_ready  input  1  initiator consumes the response.
REQ-013 rsp_rdata  output  32  read data; 0 for writes and errors.
REQ-014 rsp_err  output  1  request was out of range or misaligned.

Function
REQ-015 FSM states SHALL be IDLE, WAIT, RESP; req_ready=1 exactly when state=IDLE, rsp_valid=1 exactly when state=RESP.
REQ-016 IDLE: on an edge with req_valid=1, the block SHALL latch req_we/addr/wdata/be, load wait counter with LATENCY and go to WAIT; otherwise stay IDLE.
REQ-017 Latched request fields SHALL be used for the access; request inputs changing after acceptance SHALL have no effect.
REQ-018 WAIT: counter nonzero -> decrement, stay WAIT; counter zero -> perform access, load rsp_rdata/rsp_err, go to RESP.
REQ-019 Request accepted at edge k SHALL enter RESP at edge k+1+LATENCY; LATENCY=0 gives RESP one edge after acceptance.
REQ-020 Error SHALL be flagged when addr[1:0]!=0 or addr>=4*DEPTH_WORDS; errored request SHALL not modify storage, and rsp_rdata=0, rsp_err=1.
REQ-021 Valid read: rsp_rdata = word at addr[31:2], value as of the access edge (includes all earlier committed writes); rsp_err=0.
REQ-022 Valid write: at the access edge, each byte lane with be=1 SHALL take wdata's byte; lanes with be=0 unchanged; be=0000 is an acknowledged no-op; rsp_rdata=0, rsp_err=0.
REQ-023 RESP: rsp_rdata/rsp_err SHALL hold stable until an edge with rsp_ready=1, which returns to IDLE; rsp_ready=0 holds RESP indefinitely.
REQ-024 rsp_ready outside RESP SHALL be ignored; req_valid outside IDLE SHALL be ignored (not queued).
REQ-025 One request outstanding at most; minimum request-to-request spacing SHALL be LATENCY+3 cycles (acceptance, LATENCY+1 cycles to RESP, one RESP cycle with rsp_ready=1).
REQ-026 Storage SHALL be a DEPTH_WORDS x 32 array with no read port other than the FSM access; contents undefined at power-up.

Reset
REQ-027 On an edge with rst=0: state=IDLE, counter=0, rsp_rdata=0, rsp_err=0, latched request cleared; req_ready=1, rsp_valid=0 from the next cycle.
REQ-028 Reset SHALL NOT alter storage contents.
REQ-029 Reset in WAIT before the access edge SHALL discard the request (no write commits); reset in RESP SHALL drop the pending response.
REQ-030 Reset has priority over all other events on the same edge, including acceptance and access.

Verification
REQ-031 Write addr=0x10, wdata=0xDEADBEEF, be=1111, then read 0x10 (LATENCY=2) -> write rsp at edge k+3 err=0; read rsp_rdata=0xDEADBEEF, err=0.
REQ-032 Word 0x10=0xDEADBEEF, write wdata=0x11223344 be=0101, read -> rsp_rdata=0xDE22BE44.
REQ-033 Read addr=0x12 and addr=4*DEPTH_WORDS -> rsp_err=1, rsp_rdata=0, storage unchanged on re-read.
REQ-034 Hold rsp_ready=0 for 5 cycles in RESP, toggle req_valid/addr -> rsp_valid and rsp_rdata stable, req_ready=0, no new acceptance; rsp_ready=1 -> IDLE next edge.
REQ-035 Accept write 0x20 wdata=0x55AA55AA, assert rst=0 one edge after acceptance (LATENCY=2) -> rsp_valid never asserts, later read 0x20 returns prior value.
REQ-036 LATENCY=0, back-to-back requests with rsp_ready tied 1 -> one acceptance every 3 cycles, rsp_valid one cycle after each acceptance edge.
